// File: rtl/scene_hit_reducer.sv
// Closest-hit reducer: collects N_CORES AABB lane results per ray and picks the smallest hit tmin
// through a registered pairwise tree. Optional counters via `SCENE_HIT_REDUCER_STATS_EN.
package scene_hit_reducer_pkg;
    localparam int RES_W = 24;

    typedef struct packed {
        logic                    ray_hit;
        logic signed [RES_W-1:0] tmin;
        logic        [RES_W-1:0] color;
        logic        [RES_W-1:0] normal;
        logic signed [RES_W-1:0] box_min;
        logic signed [RES_W-1:0] box_max;
    } AABB_result_t;
endpackage

module scene_hit_reducer
    import scene_hit_reducer_pkg::*;
#(
    parameter int               N_CORES = 8,
    parameter int               WIDTH   = 24,
    parameter int               Q_BITS  = 12,
    parameter int               TAG_W   = 16,
    parameter logic [WIDTH-1:0] MAX     = 24'h7FFFFF,
    localparam int              LEVELS  = $clog2(N_CORES),
    localparam int              IDX_W   = (LEVELS > 0) ? LEVELS : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_CORES-1:0]              lane_valid,
    output logic [N_CORES-1:0]              lane_ready,
    input  AABB_result_t [N_CORES-1:0]      lane_result,
    input  logic [N_CORES-1:0][TAG_W-1:0]   lane_tag,
    output logic                            valid_out,
    input  logic                            ready_in,
    output AABB_result_t                    result_out,
    output logic [IDX_W-1:0]                hit_index,
    output logic [TAG_W-1:0]                tag_out,
    output logic                            tag_err
`ifdef SCENE_HIT_REDUCER_STATS_EN
    ,
    output logic [31:0]                     ray_count,
    output logic [31:0]                     hit_count
`endif
);
    localparam int P     = 1 << LEVELS;
    localparam int NI_W  = $clog2(P + 1);
    localparam int LVL_W = (LEVELS > 0) ? $clog2(LEVELS + 1) : 1;

    localparam AABB_result_t NO_HIT = '{
        ray_hit: 1'b0,
        tmin:    MAX,
        color:   '0,
        normal:  '0,
        box_min: {1'b1, {(WIDTH-1){1'b0}}},
        box_max: MAX
    };

    // The result record layout is fixed by the package; reject builds that disagree with it.
    if (WIDTH != RES_W || Q_BITS >= WIDTH) begin : g_cfg_err
        $error("scene_hit_reducer: WIDTH must equal RES_W and exceed Q_BITS");
    end

    typedef enum logic [1:0] {ST_COLLECT, ST_REDUCE, ST_OUTPUT} state_t;

    state_t                    state_q, state_d;
    logic [N_CORES-1:0]        captured_q, captured_d;
    AABB_result_t [N_CORES-1:0] lane_res_q, lane_res_d;
    logic [TAG_W-1:0]          ref_tag_q, ref_tag_d;
    logic                      tag_err_q, tag_err_d;
    logic [LVL_W-1:0]          lvl_q, lvl_d;
    logic signed [WIDTH-1:0]   node_key_q [P];
    logic signed [WIDTH-1:0]   node_key_d [P];
    logic [NI_W-1:0]           node_idx_q [P];
    logic [NI_W-1:0]           node_idx_d [P];
    AABB_result_t              result_q, result_d;
    logic [IDX_W-1:0]          hit_index_q, hit_index_d;
    logic [TAG_W-1:0]          tag_out_q, tag_out_d;
    logic                      ref_set;
    AABB_result_t              win_res;

    always_comb begin
        state_d     = state_q;
        captured_d  = captured_q;
        lane_res_d  = lane_res_q;
        ref_tag_d   = ref_tag_q;
        tag_err_d   = tag_err_q;
        lvl_d       = lvl_q;
        node_key_d  = node_key_q;
        node_idx_d  = node_idx_q;
        result_d    = result_q;
        hit_index_d = hit_index_q;
        tag_out_d   = tag_out_q;
        lane_ready  = '0;
        ref_set     = (captured_q != '0);
        win_res     = NO_HIT;

        case (state_q)
            ST_COLLECT: begin
                lane_ready = ~captured_q;
                // Lowest-index lane of the first capture cycle provides the reference tag.
                for (int i = 0; i < N_CORES; i++) begin
                    if (lane_valid[i] && !captured_q[i]) begin
                        captured_d[i] = 1'b1;
                        lane_res_d[i] = lane_result[i];
                        if (!ref_set) begin
                            ref_tag_d = lane_tag[i];
                            ref_set   = 1'b1;
                        end else if (lane_tag[i] != ref_tag_d) begin
                            tag_err_d = 1'b1;
                        end
                    end
                end
                if (&captured_d) begin
                    state_d = ST_REDUCE;
                    lvl_d   = '0;
                end
            end

            ST_REDUCE: begin
                if (lvl_q == '0) begin
                    for (int i = 0; i < N_CORES; i++) begin
                        node_key_d[i] = lane_res_q[i].ray_hit ? lane_res_q[i].tmin : MAX;
                        node_idx_d[i] = NI_W'(i);
                    end
                    for (int i = N_CORES; i < P; i++) begin
                        node_key_d[i] = MAX;
                        node_idx_d[i] = NI_W'(N_CORES);
                    end
                end else begin
                    // Left child always carries the lower lane indices, so it wins ties.
                    for (int i = 0; i < P / 2; i++) begin
                        if (node_key_q[2*i] <= node_key_q[2*i+1]) begin
                            node_key_d[i] = node_key_q[2*i];
                            node_idx_d[i] = node_idx_q[2*i];
                        end else begin
                            node_key_d[i] = node_key_q[2*i+1];
                            node_idx_d[i] = node_idx_q[2*i+1];
                        end
                    end
                end

                if (lvl_q == LVL_W'(LEVELS)) begin
                    for (int j = 0; j < N_CORES; j++) begin
                        if (node_idx_d[0] == NI_W'(j)) win_res = lane_res_q[j];
                    end
                    if (win_res.ray_hit) begin
                        result_d    = win_res;
                        hit_index_d = IDX_W'(node_idx_d[0]);
                    end else begin
                        result_d    = NO_HIT;
                        hit_index_d = '0;
                    end
                    tag_out_d = ref_tag_q;
                    state_d   = ST_OUTPUT;
                end else begin
                    lvl_d = lvl_q + LVL_W'(1);
                end
            end

            ST_OUTPUT: begin
                if (ready_in) begin
                    captured_d = '0;
                    state_d    = ST_COLLECT;
                end
            end

            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_COLLECT;
            captured_q  <= '0;
            lane_res_q  <= '0;
            ref_tag_q   <= '0;
            tag_err_q   <= 1'b0;
            lvl_q       <= '0;
            result_q    <= NO_HIT;
            hit_index_q <= '0;
            tag_out_q   <= '0;
            for (int i = 0; i < P; i++) begin
                node_key_q[i] <= '0;
                node_idx_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            captured_q  <= captured_d;
            lane_res_q  <= lane_res_d;
            ref_tag_q   <= ref_tag_d;
            tag_err_q   <= tag_err_d;
            lvl_q       <= lvl_d;
            result_q    <= result_d;
            hit_index_q <= hit_index_d;
            tag_out_q   <= tag_out_d;
            node_key_q  <= node_key_d;
            node_idx_q  <= node_idx_d;
        end
    end

    assign valid_out  = (state_q == ST_OUTPUT);
    assign result_out = result_q;
    assign hit_index  = hit_index_q;
    assign tag_out    = tag_out_q;
    assign tag_err    = tag_err_q;

`ifdef SCENE_HIT_REDUCER_STATS_EN
    logic [31:0] ray_count_q, ray_count_d;
    logic [31:0] hit_count_q, hit_count_d;

    always_comb begin
        ray_count_d = ray_count_q;
        hit_count_d = hit_count_q;
        if (valid_out && ready_in) begin
            ray_count_d = ray_count_q + 32'd1;
            if (result_q.ray_hit) hit_count_d = hit_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ray_count_q <= '0;
            hit_count_q <= '0;
        end else begin
            ray_count_q <= ray_count_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign ray_count = ray_count_q;
    assign hit_count = hit_count_q;
`endif
endmodule

// File: tb/tb_scene_hit_reducer.sv
// Scoreboard bench for scene_hit_reducer with N_CORES=8: closest hit, ties, misses,
// staggered lanes with stall, tag mismatch and mid-reduce reset.
module tb_scene_hit_reducer;
    import scene_hit_reducer_pkg::*;

    localparam int N = 8;
    localparam logic signed [23:0] MAXV = 24'sh7FFFFF;

    typedef struct {
        AABB_result_t res;
        logic [2:0]   idx;
        logic [15:0]  tag;
    } exp_t;

    logic                  clk;
    logic                  reset;
    logic [N-1:0]          lane_valid;
    logic [N-1:0]          lane_ready;
    AABB_result_t [N-1:0]  lane_result;
    logic [N-1:0][15:0]    lane_tag;
    logic                  valid_out;
    logic                  ready_in;
    AABB_result_t          result_out;
    logic [2:0]            hit_index;
    logic [15:0]           tag_out;
    logic                  tag_err;
`ifdef SCENE_HIT_REDUCER_STATS_EN
    logic [31:0]           ray_count;
    logic [31:0]           hit_count;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    AABB_result_t no_hit;

    scene_hit_reducer #(.N_CORES(N)) dut (
        .clk(clk), .reset(reset),
        .lane_valid(lane_valid), .lane_ready(lane_ready),
        .lane_result(lane_result), .lane_tag(lane_tag),
        .valid_out(valid_out), .ready_in(ready_in),
        .result_out(result_out), .hit_index(hit_index),
        .tag_out(tag_out), .tag_err(tag_err)
`ifdef SCENE_HIT_REDUCER_STATS_EN
        , .ray_count(ray_count), .hit_count(hit_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic reset_dut();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic set_ray(input logic [15:0] tag);
        for (int i = 0; i < N; i++) begin
            lane_result[i].ray_hit = 1'b0;
            lane_result[i].tmin    = 24'($urandom);
            lane_result[i].color   = 24'($urandom);
            lane_result[i].normal  = 24'($urandom);
            lane_result[i].box_min = 24'($urandom);
            lane_result[i].box_max = 24'($urandom);
            lane_tag[i]            = tag;
        end
    endtask

    task automatic set_hit(input int i, input logic [23:0] tmin, input logic [23:0] color);
        lane_result[i].ray_hit = 1'b1;
        lane_result[i].tmin    = tmin;
        lane_result[i].color   = color;
    endtask

    // Independent closest-hit model: strict less-than scan keeps the lowest index on ties.
    task automatic push_expected(input logic [15:0] tag);
        exp_t e;
        int best;
        logic signed [23:0] bk, k;
        best = 0;
        bk = lane_result[0].ray_hit ? lane_result[0].tmin : MAXV;
        for (int i = 1; i < N; i++) begin
            k = lane_result[i].ray_hit ? lane_result[i].tmin : MAXV;
            if (k < bk) begin
                bk = k;
                best = i;
            end
        end
        if (lane_result[best].ray_hit) begin
            e.res = lane_result[best];
            e.idx = 3'(best);
        end else begin
            e.res = no_hit;
            e.idx = 3'd0;
        end
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic send_all();
        @(posedge clk);
        #1 lane_valid = '1;
        @(posedge clk);
        #1 lane_valid = '0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if (valid_out) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic score_output(input string name);
        bit ok;
        exp_t e;
        wait_valid(ok);
        checks++;
        if (!ok || sb.size() == 0) begin
            errors++;
            $display("FAIL %s timeout/empty: valid_out=%b queued=%0d", name, valid_out, sb.size());
            return;
        end
        e = sb.pop_front();
        checks++;
        if (result_out !== e.res) begin
            errors++;
            $display("FAIL %s result: got %h want %h", name, result_out, e.res);
        end
        checks++;
        if (hit_index !== e.idx) begin
            errors++;
            $display("FAIL %s hit_index: got %0d want %0d", name, hit_index, e.idx);
        end
        checks++;
        if (tag_out !== e.tag) begin
            errors++;
            $display("FAIL %s tag_out: got %h want %h", name, tag_out, e.tag);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL %s release: valid_out got %b want 0", name, valid_out);
        end
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (valid_out !== 1'b0 || result_out !== no_hit || hit_index !== 3'd0 ||
            tag_out !== 16'd0 || tag_err !== 1'b0 || lane_ready !== 8'hFF) begin
            errors++;
            $display("FAIL reset_state: vo=%b res=%h idx=%0d tag=%h err=%b rdy=%h want 0/%h/0/0/0/ff",
                     valid_out, result_out, hit_index, tag_out, tag_err, lane_ready, no_hit);
        end
    endtask

    task automatic test_closest_hit();
        set_ray(16'h0042);
        set_hit(2, 24'h002000, 24'hAA0002);
        set_hit(5, 24'h001000, 24'hBB0005);
        push_expected(16'h0042);
        send_all();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: valid_out got %b want 0 at E0+3", valid_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid_out !== 1'b1) begin
            errors++;
            $display("FAIL latency: valid_out got %b want 1 at E0+4", valid_out);
        end
        score_output("closest_hit");
        checks++;
        if (tag_err !== 1'b0) begin
            errors++;
            $display("FAIL closest_tag_err: got %b want 0", tag_err);
        end
    endtask

    task automatic test_tie_break();
        set_ray(16'h0007);
        set_hit(1, 24'h000800, 24'h111111);
        set_hit(6, 24'h000800, 24'h666666);
        push_expected(16'h0007);
        send_all();
        score_output("tie_break");
    endtask

    task automatic test_all_miss();
        set_ray(16'h0100);
        push_expected(16'h0100);
        send_all();
        score_output("all_miss");
    endtask

    task automatic test_signed();
        set_ray(16'h0200);
        set_hit(0, 24'h000010, 24'h000ABC);
        set_hit(4, 24'hFFFFFB, 24'h000DEF);
        set_hit(7, 24'h400000, 24'h000777);
        push_expected(16'h0200);
        send_all();
        score_output("signed_min");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            set_ray(16'(r + 16'h0300));
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1)
                    set_hit(i, 24'($signed($urandom_range(0, 3) * 16) - 16), 24'($urandom));
            end
            push_expected(16'(r + 16'h0300));
            send_all();
            score_output("random");
        end
    endtask

    task automatic test_stagger_stall();
        bit ok;
        exp_t e;
        set_ray(16'h0055);
        set_hit(3, 24'h000300, 24'h333333);
        set_hit(6, 24'h000200, 24'h666666);
        push_expected(16'h0055);
        ready_in = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            @(posedge clk);
            #1 lane_valid = 8'(1 << k);
        end
        @(posedge clk);
        #1 lane_valid = '0;
        checks++;
        if (lane_ready !== 8'h00) begin
            errors++;
            $display("FAIL stagger_reduce_ready: got %h want 00", lane_ready);
        end
        wait_valid(ok);
        checks++;
        if (!ok || sb.size() == 0) begin
            errors++;
            $display("FAIL stagger timeout/empty: valid_out=%b queued=%0d", valid_out, sb.size());
            ready_in = 1'b1;
            return;
        end
        e = sb.pop_front();
        for (int t = 0; t < 6; t++) begin
            checks++;
            if (valid_out !== 1'b1 || result_out !== e.res || hit_index !== e.idx ||
                tag_out !== e.tag || lane_ready !== 8'h00) begin
                errors++;
                $display("FAIL stall_hold[%0d]: vo=%b res=%h idx=%0d tag=%h rdy=%h want 1/%h/%0d/%h/00",
                         t, valid_out, result_out, hit_index, tag_out, lane_ready, e.res, e.idx, e.tag);
            end
            if (t == 5) ready_in = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (lane_ready !== 8'hFF || valid_out !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: rdy=%h vo=%b want ff/0", lane_ready, valid_out);
        end
    endtask

    task automatic test_tag_mismatch();
        set_ray(16'h0042);
        lane_tag[3] = 16'h0043;
        set_hit(3, 24'h000100, 24'h000333);
        push_expected(16'h0042);
        send_all();
        score_output("tag_mismatch");
        checks++;
        if (tag_err !== 1'b1) begin
            errors++;
            $display("FAIL tag_err_set: got %b want 1", tag_err);
        end
        set_ray(16'h0044);
        push_expected(16'h0044);
        send_all();
        score_output("tag_after");
        checks++;
        if (tag_err !== 1'b1) begin
            errors++;
            $display("FAIL tag_err_sticky: got %b want 1", tag_err);
        end
        reset_dut();
        checks++;
        if (tag_err !== 1'b0) begin
            errors++;
            $display("FAIL tag_err_reset: got %b want 0", tag_err);
        end
    endtask

    task automatic test_reset_mid_reduce();
        bit seen;
        set_ray(16'h0900);
        set_hit(1, 24'h000050, 24'h000111);
        send_all();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if (valid_out !== 1'b0 || lane_ready !== 8'hFF) begin
            errors++;
            $display("FAIL mid_reset: vo=%b rdy=%h want 0/ff", valid_out, lane_ready);
        end
`ifdef SCENE_HIT_REDUCER_STATS_EN
        checks++;
        if (ray_count !== 32'd0 || hit_count !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_stats: rays=%0d hits=%0d want 0/0", ray_count, hit_count);
        end
`endif
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (valid_out) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_reset_phantom: valid_out got 1 want 0");
        end
        set_ray(16'h0A00);
        set_hit(2, 24'h000020, 24'h000222);
        push_expected(16'h0A00);
        send_all();
        score_output("post_reset_1");
        set_ray(16'h0A01);
        push_expected(16'h0A01);
        send_all();
        score_output("post_reset_2");
        set_ray(16'h0A02);
        set_hit(7, 24'h000030, 24'h000777);
        push_expected(16'h0A02);
        send_all();
        score_output("post_reset_3");
`ifdef SCENE_HIT_REDUCER_STATS_EN
        checks++;
        if (ray_count !== 32'd3 || hit_count !== 32'd2) begin
            errors++;
            $display("FAIL stats: rays=%0d hits=%0d want 3/2", ray_count, hit_count);
        end
`endif
    endtask

    initial begin
        no_hit.ray_hit = 1'b0;
        no_hit.tmin    = 24'h7FFFFF;
        no_hit.color   = 24'h0;
        no_hit.normal  = 24'h0;
        no_hit.box_min = 24'h800000;
        no_hit.box_max = 24'h7FFFFF;
        reset      = 1'b1;
        lane_valid = '0;
        ready_in   = 1'b1;
        set_ray(16'h0000);

        test_reset();
        test_closest_hit();
        test_tie_break();
        test_all_miss();
        test_signed();
        test_random();
        test_stagger_stall();
        test_tag_mismatch();
        test_reset_mid_reduce();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
